load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have the parameter ADDR_W, default 32, meaning the byte-address width on the core and bus sides.
REQ-002 SHALL have the port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have the port rst_n_i, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have the port mem_rd_i, input, 1 bit: load request from the decoded mem_rd control.
REQ-005 SHALL have the port mem_wr_i, input, 1 bit: store request from the decoded mem_wr control.
REQ-006 SHALL have the port funct3_i, input, 3 bits: access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 SHALL have the port addr_i, input, ADDR_W bits: the byte address from the ALU sum.
REQ-008 SHALL have the port wdata_i, input, 32 bits: store data (rs2).
REQ-009 SHALL have the port stall_o, output, 1 bit: holds the pipeline while an access is in progress.
REQ-010 SHALL have the port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have the port exc_o, output, 1 bit: misaligned address or illegal funct3; valid when done_o=1.
REQ-012 SHALL have the port rdata_o, output, 32 bits: extended load result; valid when done_o=1 for a load.
REQ-013 SHALL have the bus-side ports: bus_valid_o (1 bit, out), bus_ready_i (1 bit, in), bus_we_o (1 bit, out), bus_addr_o (ADDR_W bits, out, word-aligned), bus_be_o (4 bits, out), bus_wdata_o (32 bits, out), bus_rvalid_i (1 bit, in), bus_rdata_i (32 bits, in).

Function
REQ-014 SHALL implement the states IDLE, REQ, RESP and DONE.
REQ-015 A request SHALL be defined as mem_rd_i|mem_wr_i sampled in IDLE; if both are high, the store SHALL be ignored and the access treated as a load.
REQ-016 In IDLE with a legal, aligned request, the block SHALL register addr (with [1:0] cleared), be, wdata and we, and go to REQ.
REQ-017 In IDLE with a misaligned access (h: a[0]=1; w: a[1:0]!=0) or illegal funct3 (011, 110, 111; stores additionally 100, 101), the block SHALL go to DONE with exc_o=1 and make no bus access.
REQ-018 Byte enables SHALL be: b = 0001<<a[1:0]; h = 0011<<a[1:0]; w = 1111.
REQ-019 Store data SHALL be replicated across lanes: b as {4{wdata[7:0]}}, h as {2{wdata[15:0]}}, w as wdata.
REQ-020 In REQ, bus_valid_o SHALL be 1 with addr, be, we and wdata held stable until a cycle with bus_ready_i=1.
REQ-021 On handshake in REQ: a store SHALL go to DONE; a load SHALL go to RESP.
REQ-022 In RESP, on bus_rvalid_i=1 the block SHALL capture the lane shifted right by 8*a[1:0], sign-extend (b, h) or zero-extend (bu, hu, w), and go to DONE.
REQ-023 bus_rvalid_i SHALL be ignored outside RESP.
REQ-024 There SHALL be no timeout; REQ and RESP wait indefinitely.
REQ-025 In DONE, done_o SHALL be 1, stall_o SHALL be 0, requests SHALL be ignored, and the next state SHALL be IDLE.
REQ-026 rdata_o SHALL hold its value until the next load completion; exc_o SHALL be 1 only in DONE.
REQ-027 stall_o SHALL be 1 in REQ and RESP, and combinationally 1 in IDLE when a request is present and DONE is not next with exc; otherwise 0.
REQ-028 Minimum latency SHALL be: store 2 cycles request-to-done (bus_ready_i=1 on first REQ cycle); load 3 cycles (rvalid on first RESP cycle).
REQ-029 bus_valid_o SHALL be 0 in every state except REQ.

Reset
REQ-030 While rst_n_i=0 the block SHALL be in IDLE with bus_valid_o, bus_we_o, done_o, exc_o, stall_o = 0 and bus_addr_o, bus_be_o, bus_wdata_o, rdata_o = 0.
REQ-031 A reset asserted mid-access SHALL drop bus_valid_o immediately (asynchronously); a pending response SHALL be discarded.

Verification
REQ-032 sb, addr 0x103, wdata 0xAABBCCDD, ready=1 -> bus_addr 0x100, be 1000, wdata 0xDDDDDDDD, done 2 cycles after request.
REQ-033 lb, addr 0x201, rdata 0x0000F000 after 3 wait cycles -> rdata_o 0xFFFFFFF0 with done; lbu in the same case -> 0x000000F0.
REQ-034 lw, addr 0x302 -> exc_o=1 with done next cycle, bus_valid_o never asserted; funct3 011 load -> same.
REQ-035 sw, ready low 5 cycles -> bus_valid_o and bus fields stable for 6 cycles, stall_o=1 throughout, done after ready.
REQ-036 rst_n_i low during RESP of lh -> outputs zero immediately; a late bus_rvalid_i after release produces no done_o.
REQ-037 mem_rd_i=mem_wr_i=1 -> load performed (bus_we_o=0); back-to-back requests -> exactly one DONE between accesses.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit and the data memory.
// The master modport is the load/store unit side; the slave modport is the memory side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              bus_valid_o;
    logic              bus_ready_i;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_be_o;
    logic [31:0]       bus_wdata_o;
    logic              bus_rvalid_i;
    logic [31:0]       bus_rdata_i;

    modport master (
        output bus_valid_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_ready_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_valid_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_ready_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns decoded byte/half/word accesses into word-aligned bus
// transactions with byte enables, lane replication and load extension.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              exc_o,
    output logic [31:0]       rdata_o,
    load_store_unit_if.master bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [1:0]          off_q, off_d;
    logic [2:0]          f3_q, f3_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                exc_q, exc_d;

    logic                req_c;
    logic                is_load_c;
    logic                illegal_c;
    logic                misaligned_c;
    logic [BE_W-1:0]     be_c;
    logic [DATA_W-1:0]   wrep_c;
    logic [DATA_W-1:0]   lane_c;
    logic [DATA_W-1:0]   ext_c;

    // Request decode; a simultaneous load and store is treated as a load.
    always_comb begin
        req_c        = mem_rd_i | mem_wr_i;
        is_load_c    = mem_rd_i;
        illegal_c    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                       (!is_load_c && funct3_i[2]);
        misaligned_c = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        case (funct3_i[1:0])
            2'b00:   begin
                be_c   = BE_W'(4'b0001 << addr_i[1:0]);
                wrep_c = {4{wdata_i[7:0]}};
            end
            2'b01:   begin
                be_c   = BE_W'(4'b0011 << addr_i[1:0]);
                wrep_c = {2{wdata_i[15:0]}};
            end
            default: begin
                be_c   = 4'b1111;
                wrep_c = wdata_i;
            end
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        lane_c = DATA_W'(bus.bus_rdata_i >> {off_q, 3'b000});
        case (f3_q)
            3'b000:  ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b100:  ext_c = {24'd0, lane_c[7:0]};
            3'b101:  ext_c = {16'd0, lane_c[15:0]};
            default: ext_c = lane_c;
        endcase
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        exc_d   = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    if (illegal_c || misaligned_c) begin
                        state_d = DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        stall_o = 1'b1;
                        addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wrep_c;
                        we_d    = !is_load_c;
                        off_d   = addr_i[1:0];
                        f3_d    = funct3_i;
                    end
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (bus.bus_ready_i) begin
                    state_d = we_q ? DONE : RESP;
                end
            end
            RESP: begin
                stall_o = 1'b1;
                if (bus.bus_rvalid_i) begin
                    rdata_d = ext_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    assign done_o          = (state_q == DONE);
    assign exc_o           = exc_q;
    assign rdata_o         = rdata_q;
    assign bus.bus_valid_o = (state_q == REQ);
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_be_o    = be_q;
    assign bus.bus_wdata_o = wdata_q;

endmodule
